// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-ported data memory
// between NUM_REQ cache requesters; sequences re/we/rdy and returns data.
module dmem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 64,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_re,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ID_W-1:0]           gnt_id,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_re,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rd_data,
    input  logic                      mem_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     gnt_q, gnt_d;
    logic                op_we_q, op_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  done_q, done_d;

    logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_a [NUM_REQ];
    logic [NUM_REQ-1:0]  pending;
    logic                found;
    logic [ID_W-1:0]     win;
    logic [ID_W:0]       idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // A requester being told done this cycle gets one cycle to drop or replace.
    assign pending = (req_re | req_we) & ~done_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && pending[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        op_we_d = op_we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (mem_rdy && found) begin
                    state_d = S_ISSUE;
                    gnt_d   = win;
                    op_we_d = req_we[win];
                    addr_d  = addr_a[win];
                    wdata_d = wdata_a[win];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rdy) begin
                    state_d        = S_IDLE;
                    done_d[gnt_q]  = 1'b1;
                    if (!op_we_q) begin
                        rdata_d = mem_rd_data;
                    end
                    if (gnt_q == ID_W'(NUM_REQ - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = gnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            op_we_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            op_we_q <= op_we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Strobes and busy come only from flops, so no input reaches them combinationally.
    assign mem_re    = (state_q == S_ISSUE) && !op_we_q;
    assign mem_we    = (state_q == S_ISSUE) &&  op_we_q;
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign gnt_id    = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;

endmodule
